// File: rtl/bs_gnrtr_n_rbtr_pkg.sv
// Shared types and defaults for the bus generator/arbiter.
// Lanes and the top both import this package.
package bs_gnrtr_n_rbtr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } bs_state_t;

    localparam int ID_W = 8;

    localparam int              DEF_BITS      = 1;
    localparam int              DEF_DRVRS     = 4;
    localparam int              DEF_PCKG_SZ   = 16;
    localparam logic [ID_W-1:0] DEF_BROADCAST = 8'hFF;

endpackage

// File: rtl/bs_lane_arbiter.sv
// One bus lane: round-robin pick of a pending device, pop its packet,
// then push it to the device(s) named by the packet's destination ID.
module bs_lane_arbiter
    import bs_gnrtr_n_rbtr_pkg::*;
#(
    parameter int              drvrs     = DEF_DRVRS,
    parameter int              pckg_sz   = DEF_PCKG_SZ,
    parameter logic [ID_W-1:0] broadcast = DEF_BROADCAST
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   d_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              d_push
);

    localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;

    bs_state_t          state, state_nxt;
    logic [GW-1:0]      grant, grant_nxt;
    logic [GW-1:0]      last_grant, last_grant_nxt;
    logic [drvrs-1:0]   pop_nxt, push_nxt;
    logic [pckg_sz-1:0] d_push_nxt;
    logic [GW-1:0]      scan_sel;
    logic               scan_hit;
    logic [ID_W-1:0]    id;

    // Round-robin scan starting just after the last served device.
    always_comb begin
        scan_sel = last_grant;
        scan_hit = 1'b0;
        for (int i = 1; i <= drvrs; i++) begin
            if (!scan_hit && pndng[(int'(last_grant) + i) % drvrs]) begin
                scan_sel = GW'((int'(last_grant) + i) % drvrs);
                scan_hit = 1'b1;
            end
        end
    end

    assign id = d_pop[grant][pckg_sz-1 -: ID_W];

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        pop_nxt        = '0;
        push_nxt       = '0;
        d_push_nxt     = d_push;
        case (state)
            IDLE: begin
                if (scan_hit) begin
                    grant_nxt         = scan_sel;
                    pop_nxt[scan_sel] = 1'b1;
                    state_nxt         = POP;
                end
            end
            POP: begin
                d_push_nxt = d_pop[grant];
                // Unknown IDs fall through with an all-zero mask: packet dropped.
                if (id == broadcast) begin
                    push_nxt        = '1;
                    push_nxt[grant] = 1'b0;
                end else begin
                    for (int i = 0; i < drvrs; i++)
                        if (int'(id) == i) push_nxt[i] = 1'b1;
                end
                state_nxt = PUSH;
            end
            PUSH: begin
                last_grant_nxt = grant;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(drvrs - 1);
            pop        <= '0;
            push       <= '0;
            d_push     <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            pop        <= pop_nxt;
            push       <= push_nxt;
            d_push     <= d_push_nxt;
        end
    end

endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// Multi-lane bus generator/arbiter: one independent lane arbiter per lane,
// each lane's delivered packet fanned out to all of its devices.
module bs_gnrtr_n_rbtr
    import bs_gnrtr_n_rbtr_pkg::*;
#(
    parameter int              bits      = DEF_BITS,
    parameter int              drvrs     = DEF_DRVRS,
    parameter int              pckg_sz   = DEF_PCKG_SZ,
    parameter logic [ID_W-1:0] broadcast = DEF_BROADCAST
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [bits-1:0][drvrs-1:0]              pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]              pop,
    output logic [bits-1:0][drvrs-1:0]              push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    for (genvar l = 0; l < bits; l++) begin : g_lane
        logic [pckg_sz-1:0] lane_d;

        bs_lane_arbiter #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .pndng  (pndng[l]),
            .d_pop  (D_pop[l]),
            .pop    (pop[l]),
            .push   (push[l]),
            .d_push (lane_d)
        );

        for (genvar d = 0; d < drvrs; d++) begin : g_fan
            assign D_push[l][d] = lane_d;
        end
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Directed bench for bs_gnrtr_n_rbtr with bits=1, drvrs=4, pckg_sz=16.
module tb_bs_gnrtr_n_rbtr;

    logic                  clk;
    logic                  reset;
    logic [0:0][3:0]       pndng;
    logic [0:0][3:0][15:0] dpop;
    logic [0:0][3:0]       pop;
    logic [0:0][3:0]       push;
    logic [0:0][3:0][15:0] dpush;

    int errs = 0;
    int checks = 0;

    bs_gnrtr_n_rbtr #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (dpop),
        .pop    (pop),
        .push   (push),
        .D_push (dpush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: pop strobe, then push mask and data, then idle.
    task automatic xact(input string tag, input logic [3:0] epop,
                        input logic [3:0] epush, input logic [15:0] edata,
                        input bit drop_pndng);
        tick();
        chk({tag, "_pop"}, pop[0], epop);
        chk({tag, "_push_in_pop"}, push[0], 4'b0000);
        if (drop_pndng) pndng = '0;
        tick();
        chk({tag, "_pop_off"}, pop[0], 4'b0000);
        chk({tag, "_push"}, push[0], epush);
        chk({tag, "_dpush"}, dpush[0][2], edata);
        tick();
        chk({tag, "_push_off"}, push[0], 4'b0000);
        chk({tag, "_pop_idle"}, pop[0], 4'b0000);
        chk({tag, "_dpush_hold"}, dpush[0][0], edata);
    endtask

    logic [3:0]  rr_pop  [5];
    logic [3:0]  rr_push [5];
    logic [15:0] rr_data [5];

    initial begin
        reset = 1'b1;
        pndng = '0;
        dpop  = '0;
        #2;
        // Reset held with everything pending: outputs stay at zero.
        reset = 1'b0;
        pndng = 4'hF;
        dpop[0][0] = 16'hFF00;
        dpop[0][1] = 16'h0001;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("rst_pop", pop[0], 4'b0000);
            chk("rst_push", push[0], 4'b0000);
            chk("rst_dpush", dpush[0][3], 16'h0000);
            tick();
        end

        reset = 1'b1;
        pndng = '0;
        tick();
        chk("idle_no_pndng", pop[0], 4'b0000);

        // Unicast from device 1 to device 2.
        pndng = 4'b0010;
        dpop[0][1] = 16'h02AB;
        xact("uni", 4'b0010, 4'b0100, 16'h02AB, 1'b1);

        // Broadcast from device 3.
        pndng = 4'b1000;
        dpop[0][3] = 16'hFF55;
        xact("bcast", 4'b1000, 4'b0111, 16'hFF55, 1'b1);

        // Invalid ID 0x07 from device 0: popped, not pushed.
        pndng = 4'b0001;
        dpop[0][0] = 16'h0711;
        tick();
        chk("inv_pop", pop[0], 4'b0001);
        pndng = '0;
        tick();
        chk("inv_push", push[0], 4'b0000);
        tick();
        chk("inv_push2", push[0], 4'b0000);
        // Back in IDLE: a new request is served straight away.
        pndng = 4'b0010;
        dpop[0][1] = 16'h0355;
        xact("after_inv", 4'b0010, 4'b1000, 16'h0355, 1'b1);

        // Unicast back to source, and ID exactly at drvrs (invalid).
        pndng = 4'b0100;
        dpop[0][2] = 16'h02C3;
        xact("self", 4'b0100, 4'b0100, 16'h02C3, 1'b1);
        pndng = 4'b1000;
        dpop[0][3] = 16'h0499;
        xact("id_eq_drvrs", 4'b1000, 4'b0000, 16'h0499, 1'b1);

        // Fresh reset, then all devices pending continuously.
        reset = 1'b0;
        tick();
        dpop[0][0] = 16'hFF00;
        dpop[0][1] = 16'h0001;
        dpop[0][2] = 16'h0A00;
        dpop[0][3] = 16'h0300;
        pndng = 4'hF;
        reset = 1'b1;
        rr_pop  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_push = '{4'b1110, 4'b0001, 4'b0000, 4'b1000, 4'b1110};
        rr_data = '{16'hFF00, 16'h0001, 16'h0A00, 16'h0300, 16'hFF00};
        for (int k = 0; k < 5; k++)
            xact($sformatf("rr%0d", k), rr_pop[k], rr_push[k], rr_data[k], 1'b0);

        // Reset during PUSH of device 1's packet.
        tick();
        chk("mid_pop", pop[0], 4'b0010);
        tick();
        chk("mid_push", push[0], 4'b0001);
        reset = 1'b0;
        #1;
        chk("async_push", push[0], 4'b0000);
        chk("async_dpush", dpush[0][1], 16'h0000);
        chk("async_pop", pop[0], 4'b0000);
        tick();
        chk("held_push", push[0], 4'b0000);
        reset = 1'b1;
        tick();
        chk("post_rst_pop", pop[0], 4'b0001);
        tick();
        chk("post_rst_push", push[0], 4'b1110);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/bs_gnrtr_n_rbtr.md
BS_GNRTR_N_RBTR -- requirements
Module: bs_gnrtr_n_rbtr

Interface
REQ-001 Parameter bits, default 1, number of independent bus lanes.
REQ-002 Parameter drvrs, default 4, number of devices (FIFO ports) per lane.
REQ-003 Parameter pckg_sz, default 16, packet width in bits; SHALL be at least 9.
REQ-004 Parameter broadcast, default 8'hFF, destination ID meaning "all devices except source".
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 pndng  input  [bits-1:0][drvrs-1:0]  device FIFO holds at least one packet.
REQ-008 D_pop  input  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  head-of-FIFO packet from each device; valid whenever its pndng is 1.
REQ-009 pop  output  [bits-1:0][drvrs-1:0]  one-cycle read strobe to a device FIFO.
REQ-010 push  output  [bits-1:0][drvrs-1:0]  one-cycle write strobe into a device receive FIFO.
REQ-011 D_push  output  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  packet delivered to devices; all entries of a lane carry the same value.

Function
REQ-012 Each lane SHALL operate independently and identically.
REQ-013 Packet destination ID SHALL be D_pop[pckg_sz-1 -: 8]; the remaining bits are payload and SHALL pass unmodified.
REQ-014 Each lane SHALL run an FSM with states IDLE, POP, PUSH.
REQ-015 IDLE: if any pndng bit is 1 at a rising edge, grant the first pending device scanning from last_grant+1 modulo drvrs, and go to POP; otherwise stay in IDLE.
REQ-016 POP: pop[grant] SHALL be 1 for exactly one cycle; D_pop[grant] SHALL be captured at the end of that cycle; next state PUSH.
REQ-017 PUSH: for one cycle, D_push SHALL equal the captured packet and push SHALL be asserted per REQ-018..020; next state IDLE; last_grant <= grant.
REQ-018 Unicast (ID < drvrs): push[ID] only, including ID equal to source.
REQ-019 Broadcast (ID == broadcast): push to every device except the source.
REQ-020 Invalid ID (>= drvrs and != broadcast): packet dropped, no push asserted, FSM still returns to IDLE.
REQ-021 pop, push SHALL be registered outputs, never asserted outside POP/PUSH respectively; at most one pop bit per lane high per cycle.
REQ-022 D_push SHALL hold its last value outside PUSH.
REQ-023 Throughput: one packet per 3 cycles per lane; pndng dropping while in POP/PUSH SHALL NOT abort the transaction.

Reset
REQ-024 While reset is 0, pop, push, D_push SHALL be 0 immediately (asynchronously), FSM SHALL be IDLE, and last_grant SHALL be drvrs-1, so device 0 has first priority after release.
REQ-025 Reset asserted mid-transaction SHALL discard the in-flight packet without any push.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef, the 8-bit ID-width constant and the default parameter values.
REQ-027 One sub-module, bs_lane_arbiter, SHALL implement a single lane and be instantiated bits times by a generate loop.

Verification (drvrs=4, pckg_sz=16, bits=1)
REQ-028 Hold reset=0 with pndng=4'hF -> pop, push, D_push all 0 throughout.
REQ-029 Device 1 pending, D_pop[1]=16'h02AB -> pop[1] high one cycle, next cycle push=4'b0100 with D_push=16'h02AB.
REQ-030 Device 3 pending, D_pop[3]=16'hFF55 -> pop[3] once, then push=4'b0111, D_push=16'hFF55.
REQ-031 pndng=4'hF held continuously after reset -> pop order devices 0,1,2,3,0, one every 3 cycles.
REQ-032 Device 0 pending with D_pop[0]=16'h0711 -> pop[0] once, push stays 4'b0000, FSM returns to IDLE.
REQ-033 Reset asserted during PUSH -> push drops to 0 at once; after release with pndng=4'hF, first pop is to device 0.
